// File: rtl/commit_trace_buf_if.sv
// Commit-capture and trace-drain signal bundle between the WB probe and the trace consumer.
// The master side drives commits and out_ready; the slave side (the buffer) drives the head record.
interface commit_trace_buf_if #(
  parameter int PC_WD      = 64,
  parameter int INST_WD    = 32,
  parameter int RF_DATA_WD = 64,
  parameter int SEQ_WD     = 32
) ();
  logic                  ws_valid;
  logic [PC_WD-1:0]      wb_pc;
  logic [INST_WD-1:0]    wb_inst;
  logic                  wb_rf_wen;
  logic [4:0]            wb_rf_wnum;
  logic [RF_DATA_WD-1:0] wb_rf_wdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WD-1:0]      out_pc;
  logic [INST_WD-1:0]    out_inst;
  logic                  out_wen;
  logic [4:0]            out_wnum;
  logic [RF_DATA_WD-1:0] out_wdata;
  logic [SEQ_WD-1:0]     out_seq;

  modport master (
    output ws_valid, wb_pc, wb_inst, wb_rf_wen, wb_rf_wnum, wb_rf_wdata, out_ready,
    input  out_valid, out_pc, out_inst, out_wen, out_wnum, out_wdata, out_seq
  );

  modport slave (
    input  ws_valid, wb_pc, wb_inst, wb_rf_wen, wb_rf_wnum, wb_rf_wdata, out_ready,
    output out_valid, out_pc, out_inst, out_wen, out_wnum, out_wdata, out_seq
  );
endinterface

// File: rtl/commit_trace_buf.sv
// WB-stage commit trace FIFO: sequence-stamps every commit, accounts for lost ones,
// and sequences end-of-simulation as stop -> delayed halt_req -> drain -> halt_done.
module commit_trace_buf #(
  parameter int PC_WD      = 64,
  parameter int INST_WD    = 32,
  parameter int RF_DATA_WD = 64,
  parameter int DEPTH      = 8,
  parameter int HALT_DLY   = 4,
  parameter int MODE       = 0,
  parameter int SEQ_WD     = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  commit_trace_buf_if.slave        tr,
  input  logic                     stop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic                     halt_req,
  output logic                     halt_done
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_WD-1:0]      pc;
    logic [INST_WD-1:0]    inst;
    logic                  wen;
    logic [4:0]            wnum;
    logic [RF_DATA_WD-1:0] wdata;
    logic [SEQ_WD-1:0]     seq;
  } rec_t;

  typedef enum logic [1:0] {RUN, HALT_WAIT, DRAIN, DONE} state_t;

  state_t              state;
  rec_t                mem [DEPTH];
  rec_t                wr_rec;
  rec_t                head;
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [SEQ_WD-1:0]   seq;
  logic [HALT_DLY-1:0] halt_sr;

  logic head_valid;
  logic full;
  logic accepting;
  logic push;
  logic pop;
  logic lose;
  logic write_en;
  logic advance_rd;

  // Pointers carry a wrap bit, so occupancy is their plain difference.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == FULL_CNT);
  assign head_valid = (count != '0);

  assign accepting  = (state == RUN) || (state == HALT_WAIT);
  assign push       = tr.ws_valid && accepting;
  assign pop        = head_valid && tr.out_ready;
  assign lose       = push && full && !pop;
  assign write_en   = push && !(lose && MODE == 0);
  assign advance_rd = pop || (lose && MODE == 1);

  assign wr_rec = '{pc:    tr.wb_pc,
                    inst:  tr.wb_inst,
                    wen:   tr.wb_rf_wen,
                    wnum:  tr.wb_rf_wnum,
                    wdata: tr.wb_rf_wdata,
                    seq:   seq};

  // NOTE: storage is deliberately not reset; a cleared pointer pair makes every entry
  // unreachable and the head fields are gated to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (write_en) mem[wr_ptr[AW-1:0]] <= wr_rec;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    tr.out_valid = head_valid;
    tr.out_pc    = '0;
    tr.out_inst  = '0;
    tr.out_wen   = 1'b0;
    tr.out_wnum  = '0;
    tr.out_wdata = '0;
    tr.out_seq   = '0;
    if (head_valid) begin
      tr.out_pc    = head.pc;
      tr.out_inst  = head.inst;
      tr.out_wen   = head.wen;
      tr.out_wnum  = head.wnum;
      tr.out_wdata = head.wdata;
      tr.out_seq   = head.seq;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      seq       <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      halt_sr   <= '0;
      halt_req  <= 1'b0;
      halt_done <= 1'b0;
      state     <= RUN;
    end else begin
      if (write_en)   wr_ptr <= wr_ptr + 1'b1;
      if (advance_rd) rd_ptr <= rd_ptr + 1'b1;
      if (push)       seq    <= seq + 1'b1;

      if (lose) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end

      halt_sr <= halt_sr << 1;

      case (state)
        RUN: begin
          if (stop) begin
            halt_sr <= HALT_DLY'(1);
            state   <= HALT_WAIT;
          end
        end
        HALT_WAIT: begin
          // Top stage goes high HALT_DLY-1 edges after the load, so halt_req lands on edge HALT_DLY.
          if (halt_sr[HALT_DLY-1]) begin
            halt_req <= 1'b1;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          if (count == '0) begin
            halt_done <= 1'b1;
            state     <= DONE;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf: MODE=0 and MODE=1 instances share one stimulus stream and are
// compared every cycle against an index-based FIFO model, plus table and hand-written sequences.
module tb_commit_trace_buf;
  localparam int PC_WD      = 64;
  localparam int INST_WD    = 32;
  localparam int RF_DATA_WD = 64;
  localparam int DEPTH      = 8;
  localparam int HALT_DLY   = 4;
  localparam int SEQ_WD     = 8;
  localparam int RING       = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic [7:0]  seq;
  } rec_t;

  typedef struct {
    logic        ws_valid;
    logic [63:0] pc;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_seq;
    logic [63:0] exp_pc;
    int          exp_count;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stop = 1'b0;
  logic        ws_valid = 1'b0;
  logic [63:0] wb_pc = '0;
  logic [31:0] wb_inst = '0;
  logic        wb_rf_wen = 1'b0;
  logic [4:0]  wb_rf_wnum = '0;
  logic [63:0] wb_rf_wdata = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  count0, count1;
  logic        ovf0, ovf1;
  logic [15:0] drop0, drop1;
  logic        hreq0, hreq1;
  logic        hdone0, hdone1;

  always #5 clk = ~clk;

  commit_trace_buf_if #(.PC_WD(PC_WD), .INST_WD(INST_WD), .RF_DATA_WD(RF_DATA_WD), .SEQ_WD(SEQ_WD)) bus0 ();
  commit_trace_buf_if #(.PC_WD(PC_WD), .INST_WD(INST_WD), .RF_DATA_WD(RF_DATA_WD), .SEQ_WD(SEQ_WD)) bus1 ();

  assign bus0.ws_valid    = ws_valid;
  assign bus0.wb_pc       = wb_pc;
  assign bus0.wb_inst     = wb_inst;
  assign bus0.wb_rf_wen   = wb_rf_wen;
  assign bus0.wb_rf_wnum  = wb_rf_wnum;
  assign bus0.wb_rf_wdata = wb_rf_wdata;
  assign bus0.out_ready   = out_ready;
  assign bus1.ws_valid    = ws_valid;
  assign bus1.wb_pc       = wb_pc;
  assign bus1.wb_inst     = wb_inst;
  assign bus1.wb_rf_wen   = wb_rf_wen;
  assign bus1.wb_rf_wnum  = wb_rf_wnum;
  assign bus1.wb_rf_wdata = wb_rf_wdata;
  assign bus1.out_ready   = out_ready;

  commit_trace_buf #(.PC_WD(PC_WD), .INST_WD(INST_WD), .RF_DATA_WD(RF_DATA_WD), .DEPTH(DEPTH),
                     .HALT_DLY(HALT_DLY), .MODE(0), .SEQ_WD(SEQ_WD)) dut0 (
    .clk(clk), .resetn(resetn), .tr(bus0.slave), .stop(stop), .count(count0),
    .overflow(ovf0), .drop_cnt(drop0), .halt_req(hreq0), .halt_done(hdone0));

  commit_trace_buf #(.PC_WD(PC_WD), .INST_WD(INST_WD), .RF_DATA_WD(RF_DATA_WD), .DEPTH(DEPTH),
                     .HALT_DLY(HALT_DLY), .MODE(1), .SEQ_WD(SEQ_WD)) dut1 (
    .clk(clk), .resetn(resetn), .tr(bus1.slave), .stop(stop), .count(count1),
    .overflow(ovf1), .drop_cnt(drop1), .halt_req(hreq1), .halt_done(hdone1));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: records live at absolute indices [head, tail) of a log; plain arithmetic
  // on those two indices gives occupancy, drops and overwrites. Halt is timed by edge numbers.
  rec_t mlog [2][RING];
  int   mh [2]        = '{0, 0};
  int   mt [2]        = '{0, 0};
  int   mseq [2]      = '{0, 0};
  int   mst [2]       = '{0, 0};
  int   mstop_cyc [2] = '{0, 0};
  int   mdrop [2]     = '{0, 0};
  bit   movf [2]      = '{0, 0};
  bit   mhreq [2]     = '{0, 0};
  bit   mhdone [2]    = '{0, 0};
  int   cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int   cnt;
      int   st;
      bit   pop;
      bit   push;
      rec_t r;
      cnt = mt[m] - mh[m];
      st  = mst[m];
      if (!resetn) begin
        mh[m] = 0; mt[m] = 0; mseq[m] = 0; mst[m] = 0;
        movf[m] = 0; mdrop[m] = 0; mhreq[m] = 0; mhdone[m] = 0;
      end else begin
        pop  = (cnt > 0) && out_ready;
        push = ws_valid && (st == 0 || st == 1);
        if (push) begin
          r.pc = wb_pc; r.inst = wb_inst; r.wen = wb_rf_wen;
          r.wnum = wb_rf_wnum; r.wdata = wb_rf_wdata; r.seq = 8'(mseq[m]);
          mseq[m] = (mseq[m] + 1) % 256;
          if (cnt == DEPTH && !pop) begin
            movf[m] = 1;
            if (mdrop[m] < 65535) mdrop[m]++;
            if (m == 1) begin
              mlog[m][mt[m] % RING] = r;
              mt[m]++;
              mh[m]++;
            end
          end else begin
            mlog[m][mt[m] % RING] = r;
            mt[m]++;
          end
        end
        if (pop) mh[m]++;
        case (st)
          0: if (stop) begin mst[m] = 1; mstop_cyc[m] = cyc; end
          1: if (cyc - mstop_cyc[m] == HALT_DLY) begin mhreq[m] = 1; mst[m] = 2; end
          2: if (cnt == 0) begin mst[m] = 3; mhdone[m] = 1; end
          default: ;
        endcase
      end
    end
    cyc++;
  endtask

  task automatic compare_dut(input int m);
    rec_t        er;
    rec_t        ar;
    logic        av;
    logic [3:0]  ac;
    logic        aovf, ahr, ahd;
    logic [15:0] adr;
    string       p;
    int          ecnt;
    p    = (m == 0) ? "m0" : "m1";
    ecnt = mt[m] - mh[m];
    er   = (ecnt > 0) ? mlog[m][mh[m] % RING] : '0;
    if (m == 0) begin
      av = bus0.out_valid; ar.pc = bus0.out_pc; ar.inst = bus0.out_inst; ar.wen = bus0.out_wen;
      ar.wnum = bus0.out_wnum; ar.wdata = bus0.out_wdata; ar.seq = bus0.out_seq;
      ac = count0; aovf = ovf0; adr = drop0; ahr = hreq0; ahd = hdone0;
    end else begin
      av = bus1.out_valid; ar.pc = bus1.out_pc; ar.inst = bus1.out_inst; ar.wen = bus1.out_wen;
      ar.wnum = bus1.out_wnum; ar.wdata = bus1.out_wdata; ar.seq = bus1.out_seq;
      ac = count1; aovf = ovf1; adr = drop1; ahr = hreq1; ahd = hdone1;
    end
    check({p, ".out_valid"}, av, ecnt > 0);
    check({p, ".out_pc"}, ar.pc, er.pc);
    check({p, ".out_inst"}, ar.inst, er.inst);
    check({p, ".out_wen"}, ar.wen, er.wen);
    check({p, ".out_wnum"}, ar.wnum, er.wnum);
    check({p, ".out_wdata"}, ar.wdata, er.wdata);
    check({p, ".out_seq"}, ar.seq, er.seq);
    check({p, ".count"}, ac, ecnt);
    check({p, ".overflow"}, aovf, movf[m]);
    check({p, ".drop_cnt"}, adr, mdrop[m]);
    check({p, ".halt_req"}, ahr, mhreq[m]);
    check({p, ".halt_done"}, ahd, mhdone[m]);
  endtask

  // Inputs are held across the edge; the model advances on them, then outputs are sampled 1ns later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_dut(0);
    compare_dut(1);
  endtask

  task automatic drive(input logic v, input logic [63:0] pc);
    ws_valid    = v;
    wb_pc       = pc;
    wb_inst     = $urandom;
    wb_rf_wen   = 1'($urandom_range(1));
    wb_rf_wnum  = 5'($urandom_range(31));
    wb_rf_wdata = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    resetn = 1'b0; stop = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    step();
    resetn = 1'b1;
  endtask

  vec_t tbl [6];

  initial begin
    for (int k = 0; k < 5; k++) begin
      tbl[k].ws_valid  = 1'b1;
      tbl[k].pc        = 64'h8000_0000 + 64'(4 * k);
      tbl[k].ready     = 1'b1;
      tbl[k].exp_valid = 1'b1;
      tbl[k].exp_seq   = 8'(k);
      tbl[k].exp_pc    = 64'h8000_0000 + 64'(4 * k);
      tbl[k].exp_count = 1;
    end
    tbl[5].ws_valid = 1'b0; tbl[5].pc = '0; tbl[5].ready = 1'b1; tbl[5].exp_valid = 1'b0;
    tbl[5].exp_seq = '0; tbl[5].exp_pc = '0; tbl[5].exp_count = 0;

    // Reset state
    do_reset();
    check("reset.count", count0, 0);
    check("reset.out_valid", bus0.out_valid, 0);
    check("reset.out_pc", bus0.out_pc, 0);
    check("reset.halt_req", hreq0, 0);
    check("reset.halt_done", hdone0, 0);
    check("reset.drop_cnt", drop1, 0);

    // Basic capture, table-driven
    for (int k = 0; k < 6; k++) begin
      drive(tbl[k].ws_valid, tbl[k].pc);
      out_ready = tbl[k].ready;
      step();
      check("basic.out_valid", bus0.out_valid, tbl[k].exp_valid);
      check("basic.out_seq", bus0.out_seq, tbl[k].exp_seq);
      check("basic.out_pc", bus0.out_pc, tbl[k].exp_pc);
      check("basic.count", count0, tbl[k].exp_count);
    end
    check("basic.overflow", ovf0, 0);

    // Backpressure: MODE=0 keeps oldest, MODE=1 keeps newest
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i));
      step();
    end
    drive(1'b0, '0);
    check("bp.m0.count", count0, 8);
    check("bp.m1.count", count1, 8);
    check("bp.m0.drop_cnt", drop0, 2);
    check("bp.m1.drop_cnt", drop1, 2);
    check("bp.m0.overflow", ovf0, 1);
    check("bp.m1.overflow", ovf1, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp.m0.drain_seq", bus0.out_seq, i);
      check("bp.m1.drain_seq", bus1.out_seq, i + 2);
      step();
    end
    check("bp.m0.empty", count0, 0);
    check("bp.m1.empty", count1, 0);

    // Full FIFO with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'h3000 + 64'(4 * i));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h3100 + 64'(4 * i));
      step();
      check("pp.m0.count", count0, 8);
      check("pp.m1.count", count1, 8);
      check("pp.m0.head_seq", bus0.out_seq, i + 1);
      check("pp.m0.drop_cnt", drop0, 0);
    end
    drive(1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      check("pp.m0.drain_seq", bus0.out_seq, i + 4);
      check("pp.m1.drain_seq", bus1.out_seq, i + 4);
      step();
    end

    // Halt: delay, drain, done
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h2000 + 64'(4 * i));
      step();
    end
    drive(1'b0, '0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 1; i <= HALT_DLY; i++) begin
      step();
      check("halt.req_timing", hreq0, i == HALT_DLY);
      check("halt.done_early", hdone0, 0);
    end
    drive(1'b1, 64'hdead);
    step();
    drive(1'b0, '0);
    check("halt.drain_ignores_commit", count0, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("halt.drain_seq", bus0.out_seq, i);
      step();
    end
    check("halt.drained", count0, 0);
    check("halt.done_not_yet", hdone0, 0);
    step();
    check("halt.m0.done", hdone0, 1);
    check("halt.m1.done", hdone1, 1);
    drive(1'b1, 64'hbeef);
    step();
    drive(1'b0, '0);
    check("halt.done_ignores_commit", count0, 0);
    check("halt.done_held", hdone0, 1);

    // Reset in the middle of DRAIN
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h4000 + 64'(4 * i));
      step();
    end
    drive(1'b0, '0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < HALT_DLY; i++) step();
    check("rst.in_drain", hreq0, 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("rst.count", count0, 0);
    check("rst.out_valid", bus0.out_valid, 0);
    check("rst.halt_req", hreq0, 0);
    check("rst.halt_done", hdone0, 0);
    drive(1'b1, 64'h5000);
    step();
    drive(1'b0, '0);
    check("rst.seq_restart", bus0.out_seq, 0);
    check("rst.first_valid", bus0.out_valid, 1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      resetn    = !(($urandom_range(99) == 0) || (i % 400 == 399));
      drive($urandom_range(9) < 7, {$urandom, $urandom});
      out_ready = 1'($urandom_range(1));
      stop      = ($urandom_range(49) == 0);
      step();
    end
    resetn = 1'b1; stop = 1'b0;
    drive(1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/commit_trace_buf.md
Name: commit_trace_buf

Overview:
- Parametrised successor to the single-record commit probe.
- Captures every write-back-stage commit (pc, inst, GPR write) into a DEPTH-entry FIFO.
- Stamps each record with a sequence number; tracks dropped commits.
- Sequences end-of-simulation: delays stop, then drains the FIFO before signalling halt.
- Sits beside the WB stage. It feeds the difftest/trace consumer through a valid/ready drain port, so commits are no longer lost when the consumer samples slower than one record per cycle.

Parameters:
- PC_WD, 64, program-counter width.
- INST_WD, 32, instruction width.
- RF_DATA_WD, 64, GPR data width.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- HALT_DLY, 4, cycles from stop sample to halt request, matching the pipeline depth to retirement.
- MODE, 0, full-FIFO policy: 0 = drop newest, 1 = overwrite oldest.
- SEQ_WD, 32, sequence-number width.

Ports:
- clk in 1: clock.
- resetn in 1: synchronous active-low reset.
- ws_valid in 1: WB stage commits this cycle.
- wb_pc in PC_WD: committing pc.
- wb_inst in INST_WD: committing instruction.
- wb_rf_wen in 1: GPR write enable.
- wb_rf_wnum in 5: GPR index.
- wb_rf_wdata in RF_DATA_WD: GPR write data.
- stop in 1: ebreak/halt seen at the WB boundary.
- out_valid out 1: head record available.
- out_ready in 1: consumer accepts head.
- out_pc out PC_WD: head record pc.
- out_inst out INST_WD: head record instruction.
- out_wen out 1: head record GPR write enable.
- out_wnum out 5: head record GPR index.
- out_wdata out RF_DATA_WD: head record GPR data.
- out_seq out SEQ_WD: head record sequence number.
- count out log2(DEPTH)+1: current occupancy.
- overflow out 1: sticky; at least one commit dropped or overwritten.
- drop_cnt out 16: saturating count of lost commits.
- halt_req out 1: stop delayed by HALT_DLY cycles.
- halt_done out 1: halt reached and FIFO fully drained.

Behaviour:
- Reset (resetn=0 at posedge clk):
  - Pointers, count, seq counter, overflow, drop_cnt and the halt shift register go to 0; FSM goes to RUN.
  - All outputs go to 0 the next cycle, including out_* data fields.
  - Reset mid-drain or mid-halt discards all contents; no record survives.
- Sequence counter:
  - Increments by 1 on every cycle with ws_valid=1 in RUN or HALT_WAIT, whether the record is accepted or lost.
  - Each record carries the pre-increment value.
  - Wraps modulo 2^SEQ_WD.
  - A gap in out_seq identifies dropped commits.
- Push/pop:
  - Pop when out_valid & out_ready. Push when ws_valid and the FSM is in RUN or HALT_WAIT.
  - Record written at edge N appears at the head no earlier than N+1; there is no input-to-output bypass.
  - out_* reads the head entry combinationally from registered storage and is stable while out_valid & !out_ready.
  - Full & push & pop in the same cycle: both happen; count unchanged; no loss.
  - Full & push & no pop, MODE=0: new record discarded.
  - Full & push & no pop, MODE=1: oldest record overwritten and head advances; count stays DEPTH.
  - In either full-loss case: overflow <= 1, and drop_cnt increments unless it is already 16'hFFFF.
  - Empty & push & pop: pop is ignored (out_valid=0); push proceeds.
- Halt FSM:
  - RUN: if stop=1, load stage 0 of the HALT_DLY-deep shift register and go to HALT_WAIT. Further stop pulses are ignored until reset.
  - HALT_WAIT: commits are still captured. When the shift register output is 1, halt_req <= 1 (held) and go to DRAIN.
  - DRAIN: ws_valid is ignored; no push and no seq increment. When count == 0, go to DONE.
  - DONE: halt_done = 1, held until reset. ws_valid is ignored.
  - halt_req rises exactly HALT_DLY cycles after the stop sample edge.
  - stop and ws_valid in the same cycle: the record is captured.
- Widths: count and pointers use log2(DEPTH) bits plus a wrap bit; full = (count == DEPTH).

Test Plan:
- Basic capture: DEPTH=8, out_ready=1; 5 back-to-back commits with pc=0x80000000+4k. Expect 5 records in order with out_seq 0..4, each visible one cycle after its commit; overflow=0.
- MODE=0 backpressure: out_ready=0; 10 commits. Expect count=8, drop_cnt=2, overflow=1; the drain returns seq 0..7.
- MODE=1 backpressure: same stimulus as MODE=0. Expect count=8, drop_cnt=2; the drain returns seq 2..9.
- Full with simultaneous push and pop: fill to 8, then push and pop each cycle for 4 cycles. Expect count constant at 8, drop_cnt=0, and seq order contiguous.
- Halt: HALT_DLY=4; stop with 3 records queued and out_ready=0. Expect halt_req 4 cycles later and halt_done=0. Then set out_ready=1: the 3 records drain and halt_done=1 on the following cycle. A commit issued during DRAIN is not recorded.
- Reset mid-DRAIN: assert resetn=0 for 1 cycle. Expect count=0, out_valid=0, halt_req=0, halt_done=0, and seq restarting at 0.
